// File: rtl/pe_dataflow_sequencer.sv
// pe_dataflow_sequencer
// Job-level sequencer for the PE array edge dataflow. One job loads a weight
// group, then for each input block runs partial-sum in, input streaming, a
// fixed pipeline wait and an output drain. Beats are gated by the edge-buffer
// valid/ready handshakes.
//
// Build option: define PE_SEQ_PSUM_IN_EN to include the PSUM_IN phase.
// With it undefined (default) PSUM_IN is skipped, EN_O_In is tied low and
// psum_valid is ignored; the phase encoding is unchanged.

module pe_dataflow_sequencer #(
    parameter int W_PEGroupSize = 4,
    parameter int O_PEGroupSize = 4,
    parameter int I_PEGroupSize = W_PEGroupSize + O_PEGroupSize - 1,
    parameter int I_BlockCount  = 4,
    parameter int PIPE_LAT      = 3,
    parameter int CNT_W         = 4,
    parameter int BLK_W         = 3
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic             sclr,
    input  logic             start,
    input  logic             w_valid,
    input  logic             psum_valid,
    input  logic             i_valid,
    input  logic             o_ready,
    output logic             EN_W,
    output logic             EN_O_In,
    output logic             EN_I,
    output logic             EN_O_Out,
    output logic             ctrl_sclr,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase,
    output logic [BLK_W-1:0] blk_idx
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_W  = 3'd1,
        S_PSUM_IN = 3'd2,
        S_LOAD_I  = 3'd3,
        S_WAIT    = 3'd4,
        S_DRAIN   = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Terminal counter values: a phase ends on the beat whose count equals these.
    localparam logic [CNT_W-1:0] W_LAST    = CNT_W'(W_PEGroupSize - 1);
    localparam logic [CNT_W-1:0] O_LAST    = CNT_W'(O_PEGroupSize - 1);
    localparam logic [CNT_W-1:0] I_LAST    = CNT_W'(I_PEGroupSize - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(PIPE_LAT - 1);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(I_BlockCount - 1);

    // Phase entered after the weight load and after a non-final drain.
`ifdef PE_SEQ_PSUM_IN_EN
    localparam state_t S_BLOCK_FIRST = S_PSUM_IN;
`else
    localparam state_t S_BLOCK_FIRST = S_LOAD_I;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [BLK_W-1:0] r_blk_idx;
    logic             r_done;
    logic             r_busy;

    logic w_en_w;
    logic w_en_o_in;
    logic w_en_i;
    logic w_en_o_out;
    logic w_ctrl_sclr;

    // Accepted-beat strobes: decoded from the registered state and the
    // handshake of the active stream only, so at most one is high and none
    // glitch on a state change; a synchronous clear suppresses them.
    always_comb begin
        w_en_w      = 1'b0;
        w_en_o_in   = 1'b0;
        w_en_i      = 1'b0;
        w_en_o_out  = 1'b0;
        w_ctrl_sclr = 1'b0;
        if (!sclr) begin
            w_en_w      = (r_state == S_LOAD_W) && w_valid;
`ifdef PE_SEQ_PSUM_IN_EN
            w_en_o_in   = (r_state == S_PSUM_IN) && psum_valid;
`endif
            w_en_i      = (r_state == S_LOAD_I) && i_valid;
            w_en_o_out  = (r_state == S_DRAIN) && o_ready;
            w_ctrl_sclr = (r_state == S_IDLE) && start && !aclr;
        end
    end

`ifndef PE_SEQ_PSUM_IN_EN
    logic w_unused_psum;
    assign w_unused_psum = psum_valid;
`endif

    // Job FSM: advances a phase on the edge that accepts its last beat, with
    // the beat counter cleared on every phase change and held across stalls.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_blk_idx  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else if (sclr) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_blk_idx  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state    <= S_LOAD_W;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                        r_wait_cnt <= '0;
                        r_blk_idx  <= '0;
                    end
                end
                S_LOAD_W: begin
                    if (w_en_w) begin
                        if (r_beat_cnt == W_LAST) begin
                            r_state    <= S_BLOCK_FIRST;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
`ifdef PE_SEQ_PSUM_IN_EN
                S_PSUM_IN: begin
                    if (w_en_o_in) begin
                        if (r_beat_cnt == O_LAST) begin
                            r_state    <= S_LOAD_I;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
`endif
                S_LOAD_I: begin
                    if (w_en_i) begin
                        if (r_beat_cnt == I_LAST) begin
                            r_state    <= S_WAIT;
                            r_beat_cnt <= '0;
                            r_wait_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state    <= S_DRAIN;
                        r_wait_cnt <= '0;
                        r_beat_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_en_o_out) begin
                        if (r_beat_cnt == O_LAST) begin
                            r_beat_cnt <= '0;
                            if (r_blk_idx == BLK_LAST) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state   <= S_BLOCK_FIRST;
                                r_blk_idx <= r_blk_idx + 1'b1;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_beat_cnt <= '0;
                    r_wait_cnt <= '0;
                    r_blk_idx  <= '0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign EN_W      = w_en_w;
    assign EN_O_In   = w_en_o_in;
    assign EN_I      = w_en_i;
    assign EN_O_Out  = w_en_o_out;
    assign ctrl_sclr = w_ctrl_sclr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign phase     = r_state;
    assign blk_idx   = r_blk_idx;

endmodule

// File: doc/pe_dataflow_sequencer.md
# pe_dataflow_sequencer

Job-level sequencer for the PE array's edge dataflow. On `start` it loads one weight group, then for each of `I_BlockCount` input blocks runs partial-sum in, input streaming, pipeline wait and output drain. It drives the `EN_W`/`EN_I`/`EN_O_In`/`EN_O_Out` strobes and a pointer clear into the PE edge-address controller. Every beat is gated by the per-stream valid/ready handshakes from the edge buffers.

## Interface
- `W_PEGroupSize`, 4, weight beats per job
- `O_PEGroupSize`, 4, partial-sum beats in / output beats out per block
- `I_PEGroupSize`, `W_PEGroupSize+O_PEGroupSize-1`, input beats per block
- `I_BlockCount`, 4, blocks per job (≥1)
- `PIPE_LAT`, 3, idle cycles between last input beat and first drain beat (≥1)
- `CNT_W`, 4, beat/wait counter width; must hold max(group sizes, `PIPE_LAT`)
- `BLK_W`, 3, block counter width; must hold `I_BlockCount`

Ports:
- `clk` in 1: single clock, rising edge
- `aclr` in 1: asynchronous, active-high reset
- `sclr` in 1: synchronous clear, same effect as `aclr`
- `start` in 1: job request, sampled only in IDLE
- `w_valid` in 1: weight buffer has a beat
- `psum_valid` in 1: partial-sum buffer has a beat
- `i_valid` in 1: input buffer has a beat
- `o_ready` in 1: output buffer accepts a beat
- `EN_W`, `EN_O_In`, `EN_I`, `EN_O_Out` out 1 each: accepted-beat strobes to the edge-address controller
- `ctrl_sclr` out 1: pointer clear to the edge-address controller
- `busy` out 1: job in progress (state ≠ IDLE)
- `done` out 1: one-cycle job-complete pulse
- `phase` out 3: current state encoding
- `blk_idx` out `BLK_W`: current block index

## Operation
- States and `phase` encoding: IDLE=0, LOAD_W=1, PSUM_IN=2, LOAD_I=3, WAIT=4, DRAIN=5, DONE=6.
- IDLE
  - `start`=1 moves to LOAD_W.
  - `ctrl_sclr`=1 in that same cycle.
  - `beat_cnt`, `wait_cnt` and `blk_idx` are cleared.
- LOAD_W: `EN_W`=`w_valid`. After `W_PEGroupSize` accepted beats, go to PSUM_IN.
- PSUM_IN: `EN_O_In`=`psum_valid`. After `O_PEGroupSize` beats, go to LOAD_I.
- LOAD_I: `EN_I`=`i_valid`. After `I_PEGroupSize` beats, go to WAIT.
- WAIT: no strobes. After exactly `PIPE_LAT` cycles, go to DRAIN.
- DRAIN: `EN_O_Out`=`o_ready`. After `O_PEGroupSize` beats:
  - if `blk_idx`==`I_BlockCount-1`, go to DONE;
  - otherwise increment `blk_idx` and go to PSUM_IN.
- DONE: `done`=1 for one cycle, then IDLE. `blk_idx` is held until the next start.
- Beat counting:
  - `beat_cnt` increments only on an accepted beat (strobe high).
  - `beat_cnt` resets to 0 on every phase change.
  - Stalls (valid/ready low) hold state and counter indefinitely.
- `start` outside IDLE is ignored. It is not queued.
- At most one `EN_*` strobe is high in any cycle.

## Timing
- Strobes are combinational from state and the handshake input in the same cycle. They must not glitch on a state change.
- State, counters, `done`, `blk_idx` and `phase` are registered.
- The transition happens on the clock edge that accepts the last beat. The next phase's strobes can assert on the following cycle.
- Reset (`aclr` asynchronous, `sclr` synchronous):
  - state IDLE, all counters 0;
  - `EN_*`=0, `ctrl_sclr`=0, `busy`=0, `done`=0, `phase`=0, `blk_idx`=0.
- `sclr` while `start`=1 is high: `sclr` wins and no job is started.
- `aclr` or `sclr` mid-job aborts the job immediately. No `done` is produced.
- Defaults, all handshakes high, start accepted at cycle 0:
  - LOAD_W covers cycles 1–4.
  - Each block takes 18 cycles (4+7+3+4).
  - `done` is high at cycle 77; `busy` is low at cycle 78.

## Configuration
- `PE_SEQ_PSUM_IN_EN` defined:
  - PSUM_IN is present as described.
- `PE_SEQ_PSUM_IN_EN` undefined:
  - PSUM_IN is removed and LOAD_W/DRAIN go directly to LOAD_I.
  - `EN_O_In` is tied to 0 and `psum_valid` is ignored.
  - Phase encoding is unchanged; 2 is never produced.
  - Default job: 14 cycles per block, `done` at cycle 61.

## Test plan
- Defaults, all handshakes high, `start` at cycle 0 → `ctrl_sclr`=1 at cycle 0. Strobe counts: 4 `EN_W`, 16 `EN_O_In`, 28 `EN_I`, 16 `EN_O_Out`. `done` only at cycle 77.
- `i_valid` low for 5 cycles mid-LOAD_I of block 1 → state held, still 7 `EN_I` in the block, `done` at cycle 82.
- `o_ready` toggling 1/0 throughout → each DRAIN takes 7–8 cycles, exactly 4 `EN_O_Out` per block, `blk_idx` steps 0→1→2→3.
- `start` pulsed during DRAIN of block 2 → ignored; exactly one `done` and no second job.
- `aclr` asserted asynchronously in WAIT of block 1 → outputs return to reset values before the next edge; a `start` after release runs a full job with `done` 77 cycles later.
- Build without `PE_SEQ_PSUM_IN_EN` → `EN_O_In` is never 1, `phase` is never 2, `done` at cycle 61.
